sign_unit_seq: RTL

- Parametrised, digit-serial successor to the calculator's 16-bit combinational sign negator.
- Computes pass, negate, absolute value or negative-absolute of a WIDTH-bit two's-complement operand, DIGIT bits per clock, LSB first.
- Uses valid/ready handshakes on both input and output so the CALU datapath can stall it.
- Reports overflow and zero flags alongside each result.

---
 rtl/sign_unit_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sign_unit_seq.sv
// sign_unit_seq: digit-serial sign unit (PASS / NEG / ABS / NABS).
// Processes a WIDTH-bit two's-complement operand DIGIT bits per clock,
// LSB first, so a result appears N = WIDTH/DIGIT edges after acceptance.
// Optional macro SIGN_UNIT_SAT_EN: saturate overflowing results to the
// maximum positive value instead of returning the wrapped value.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid is never withdrawn before that edge, and nothing may be
// inferred from ready while valid is low. One operand in flight at a time.
module sign_unit_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_num,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_NABS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_neg_en;
  logic             r_ovf_pend;
  logic [WIDTH-1:0] r_out_num;
  logic             r_ovf;
  logic             r_zero;

  logic             w_neg_en;
  logic             w_is_min;
  logic [DIGIT-1:0] w_slice;
  logic             w_cout;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_result;
  logic             w_last;

  // Negate decision taken from the operand and mode presented at acceptance.
  always_comb begin
    w_neg_en = 1'b0;
    case (mode)
      MODE_PASS: w_neg_en = 1'b0;
      MODE_NEG:  w_neg_en = 1'b1;
      MODE_ABS:  w_neg_en = in_num[WIDTH-1];
      MODE_NABS: w_neg_en = ~in_num[WIDTH-1];
      default:   w_neg_en = 1'b0;
    endcase
  end

  assign w_is_min = (in_num == {1'b1, {(WIDTH-1){1'b0}}});
  assign w_last   = (r_cnt == CW'(N - 1));

  // One digit of conditional invert-and-increment; carry ripples across edges.
  assign {w_cout, w_slice} = {1'b0, r_shift[DIGIT-1:0] ^ {DIGIT{r_neg_en}}}
                             + {{DIGIT{1'b0}}, r_carry};

  generate
    if (N == 1) begin : g_single
      assign w_shift_next = w_slice;
    end else begin : g_multi
      assign w_shift_next = {w_slice, r_shift[WIDTH-1:DIGIT]};
    end
  endgenerate

`ifdef SIGN_UNIT_SAT_EN
  assign w_result = r_ovf_pend ? {1'b0, {(WIDTH-1){1'b1}}} : w_shift_next;
`else
  assign w_result = w_shift_next;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next_state = S_BUSY;
      S_BUSY:  if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready held low during reset.
  always_comb begin
    in_ready  = (r_state == S_IDLE) && !rst;
    out_valid = (r_state == S_DONE);
  end

  // Datapath: latch at acceptance, shift one digit per BUSY edge, capture result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_neg_en   <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_out_num  <= '0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift    <= in_num;
            r_neg_en   <= w_neg_en;
            r_carry    <= w_neg_en;
            r_cnt      <= '0;
            // NABS of the most-negative value is representable, so no overflow.
            r_ovf_pend <= w_neg_en && w_is_min && (mode != MODE_NABS);
          end
        end
        S_BUSY: begin
          r_shift <= w_shift_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_out_num <= w_result;
            r_ovf     <= r_ovf_pend;
            r_zero    <= (w_result == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_num = r_out_num;
  assign ovf     = r_ovf;
  assign zero    = r_zero;

endmodule
